// File: rtl/rv_skid_buf16.sv
// rv_skid_buf16: 2-entry valid/ready elastic stage (main + skid register) with no combinational out_ready->in_ready path.
// Optional per-beat parity storage and checking is enabled by defining RV_SKID_BUF16_PARITY_EN.
module rv_skid_buf16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occ
`ifdef RV_SKID_BUF16_PARITY_EN
  ,
  input  logic             din_par,
  output logic             dout_perr
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [1:0]       r_occ;

  logic w_accept;
  logic w_take;
  logic w_loadMainIn;
  logic w_loadSkid;
  logic w_loadMainSkid;

  // in_ready depends only on registered state and flush, so back-pressure never ripples upstream combinationally.
  assign in_ready  = (r_state != FULL) & ~flush;
  assign out_valid = (r_state != EMPTY);
  assign dout      = r_main;
  assign occ       = r_occ;

  assign w_accept = in_valid & in_ready;
  assign w_take   = out_valid & out_ready;

  assign w_loadMainIn   = w_accept & ((r_state == EMPTY) | ((r_state == ONE) & w_take));
  assign w_loadSkid     = w_accept & (r_state == ONE) & ~w_take;
  assign w_loadMainSkid = ~flush & (r_state == FULL) & w_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_occ   <= 2'd0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_occ   <= 2'd0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state <= ONE;
            r_occ   <= 2'd1;
          end
        end
        ONE: begin
          if (w_accept && !w_take) begin
            r_state <= FULL;
            r_occ   <= 2'd2;
          end else if (!w_accept && w_take) begin
            r_state <= EMPTY;
            r_occ   <= 2'd0;
          end
        end
        FULL: begin
          if (w_take) begin
            r_state <= ONE;
            r_occ   <= 2'd1;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_occ   <= 2'd0;
        end
      endcase
    end
  end

  // Flush leaves the data registers untouched; dout is don't-care once out_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_loadMainIn) begin
        r_main <= din;
      end else if (w_loadMainSkid) begin
        r_main <= r_skid;
      end
      if (w_loadSkid) begin
        r_skid <= din;
      end
    end
  end

`ifdef RV_SKID_BUF16_PARITY_EN
  logic r_parMain;
  logic r_parSkid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parMain <= 1'b0;
      r_parSkid <= 1'b0;
    end else begin
      if (w_loadMainIn) begin
        r_parMain <= din_par;
      end else if (w_loadMainSkid) begin
        r_parMain <= r_parSkid;
      end
      if (w_loadSkid) begin
        r_parSkid <= din_par;
      end
    end
  end

  assign dout_perr = out_valid & (^dout ^ r_parMain);
`endif

endmodule
